sort_seq_ctrl: RTL

- Sequential sort controller for one job of N unsigned words.
- Loads N words from an upstream valid/ready stream into an internal register bank.
- Sorts the bank with an odd-even transposition schedule that drives a single shared compare-exchange unit, one compare per cycle.
- Streams the sorted words out in ascending order. It replaces the parallel comparator network where area matters more than latency.

---
 rtl/sort_seq_pkg.sv | 28 ++
 rtl/sort_cmp_exch.sv | 24 ++
 rtl/sort_seq_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/sort_seq_pkg.sv
// ============================================================================
// Module : sort_seq_pkg
// Brief  : Shared types and schedule helpers for the sequential sort controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sort_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SORT = 2'd2,
    S_OUT  = 2'd3
  } sort_state_t;

  // Even passes hold ceil(N/2) passes of floor(N/2) pairs; odd passes lose one pair when N is even.
  function automatic int unsigned sort_cmp_count(input int unsigned n);
    return ((n + 1) / 2) * (n / 2) + (n / 2) * ((n - 1) / 2);
  endfunction

  function automatic int unsigned first_pair(input logic odd_pass);
    return odd_pass ? 1 : 0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sort_cmp_exch.sv
// ============================================================================
// Module : sort_cmp_exch
// Brief  : Combinational unsigned compare-exchange; equal inputs never swap.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sort_cmp_exch #(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi,
  output logic         swapped
);

  assign swapped = (x > y);
  assign lo      = swapped ? y : x;
  assign hi      = swapped ? x : y;

endmodule

`default_nettype wire

// File: rtl/sort_seq_ctrl.sv
// ============================================================================
// Module : sort_seq_ctrl
// Brief  : Loads N words, sorts them with an odd-even transposition schedule
//          over one shared compare-exchange unit, then streams them ascending.
//          Optional macro SORT_SEQ_EARLY_EXIT_EN ends SORT after a swap-free
//          even/odd pass pair.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sort_seq_ctrl
  import sort_seq_pkg::*;
#(
  parameter int W  = 8,
  parameter int N  = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic          out_last,
  output logic          busy,
  output logic [CW-1:0] sort_cycles
);

  localparam int          c_IDX_W     = $clog2(N);
  localparam int unsigned c_CMP_TOTAL = sort_cmp_count(N);
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(N - 1);

  sort_state_t        r_state, w_next_state;
  logic [W-1:0]       r_bank [N];
  logic [c_IDX_W-1:0] r_load_idx, r_out_idx, r_cmp_idx;
  logic               r_pass_odd;
  logic [CW-1:0]      r_cmp_cnt, r_sort_cycles;

  logic [c_IDX_W-1:0] w_cmp_hi_idx, w_next_first;
  logic [W-1:0]       w_lo, w_hi;
  logic               w_swapped, w_pass_end, w_last_cmp, w_early_exit;
  logic               w_sort_done, w_next_odd, w_out_last;

  sort_cmp_exch #(.W(W)) u_cmp (
    .x       (r_bank[r_cmp_idx]),
    .y       (r_bank[w_cmp_hi_idx]),
    .lo      (w_lo),
    .hi      (w_hi),
    .swapped (w_swapped)
  );

  // Pass ends when the next pair (i+2, i+3) would run off the bank; an odd
  // pass with no pairs (N == 2) is skipped by staying on even parity.
  always_comb begin
    w_cmp_hi_idx = r_cmp_idx + c_IDX_W'(1);
    w_pass_end   = (int'({1'b0, r_cmp_idx}) + 3 >= N);
    w_last_cmp   = (r_cmp_cnt == CW'(c_CMP_TOTAL - 1));
    w_next_odd   = ~r_pass_odd;
    if (w_next_odd && (N < 3)) begin
      w_next_odd = 1'b0;
    end
    w_next_first = c_IDX_W'(first_pair(w_next_odd));
    w_sort_done  = w_last_cmp || w_early_exit;
  end

`ifdef SORT_SEQ_EARLY_EXIT_EN
  logic r_pass_swap, r_prev_swap;

  assign w_early_exit = r_pass_odd && w_pass_end && !(r_pass_swap || w_swapped) && !r_prev_swap;

  always_ff @(posedge clk) begin
    if (reset || (r_state != S_SORT)) begin
      r_pass_swap <= 1'b0;
      r_prev_swap <= 1'b0;
    end else if (w_pass_end) begin
      r_prev_swap <= r_pass_swap || w_swapped;
      r_pass_swap <= 1'b0;
    end else begin
      r_pass_swap <= r_pass_swap || w_swapped;
    end
  end
`else
  assign w_early_exit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    out_data     = '0;
    w_out_last   = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next_state = S_LOAD;
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && (r_load_idx == c_LAST_IDX)) w_next_state = S_SORT;
      end
      S_SORT: begin
        busy = 1'b1;
        if (w_sort_done) w_next_state = S_OUT;
      end
      S_OUT: begin
        busy       = 1'b1;
        out_valid  = 1'b1;
        out_data   = r_bank[r_out_idx];
        w_out_last = (r_out_idx == c_LAST_IDX);
        if (out_ready && w_out_last) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign out_last    = w_out_last;
  assign sort_cycles = r_sort_cycles;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < N; k++) r_bank[k] <= '0;
      r_load_idx    <= '0;
      r_out_idx     <= '0;
      r_cmp_idx     <= '0;
      r_pass_odd    <= 1'b0;
      r_cmp_cnt     <= '0;
      r_sort_cycles <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_LOAD: begin
          if (in_valid) begin
            r_bank[r_load_idx] <= in_data;
            r_load_idx <= (r_load_idx == c_LAST_IDX) ? '0 : r_load_idx + c_IDX_W'(1);
          end
        end
        S_SORT: begin
          r_bank[r_cmp_idx]    <= w_lo;
          r_bank[w_cmp_hi_idx] <= w_hi;
          if (w_sort_done) begin
            r_sort_cycles <= r_cmp_cnt + CW'(1);
            r_cmp_cnt     <= '0;
            r_cmp_idx     <= '0;
            r_pass_odd    <= 1'b0;
          end else begin
            r_cmp_cnt <= r_cmp_cnt + CW'(1);
            if (w_pass_end) begin
              r_cmp_idx  <= w_next_first;
              r_pass_odd <= w_next_odd;
            end else begin
              r_cmp_idx <= r_cmp_idx + c_IDX_W'(2);
            end
          end
        end
        S_OUT: begin
          if (out_ready) begin
            r_out_idx <= w_out_last ? '0 : r_out_idx + c_IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
